bcd_digit_counter: RTL and testbench

- Upstream stage that generates the 4-bit BCD value consumed by the single-digit seven-segment decoder.
- Debounces two raw push-buttons (start/pause, clear).
- Runs a prescaled 0-9 up/down counter under a 3-state FSM.
- Outputs the current digit, a wrap pulse for cascading further digits, and a running flag for an LED.

---
 rtl/bcd_digit_counter.sv | 159 +++++++++++++++
 tb/tb_bcd_digit_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_counter.sv
// Single BCD digit up/down counter with debounced start/pause and clear buttons.
// Drives one seven-segment decoder digit; carry cascades to the next digit.
module bcd_digit_counter #(
   parameter int unsigned TICK_DIV        = 100000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       up_down,
   output logic [3:0] digit1,
   output logic       carry,
   output logic       running
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [PW-1:0] PscMax = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DbMax  = CW'(DEBOUNCE_CYCLES);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StPause = 2'd2;

   // Button debouncers: index 0 = start, index 1 = clear.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    level_q;
   logic [1:0]    level_dly_q;
   logic [CW-1:0] db_cnt_q [2];
   logic [1:0]    press;
   logic          start_press;
   logic          clear_press;

   assign btn_raw = {btn_clear, btn_start};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         // The level flips on the first disagreeing sample after the counter has reached the limit.
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbMax) begin
               level_q[i]  <= ~level_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign press       = level_q & ~level_dly_q;
   assign start_press = press[0];
   assign clear_press = press[1];

   // Counter FSM and prescaler.
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] psc_q, psc_d;
   logic [3:0]    digit_q, digit_d;
   logic          carry_q, carry_d;
   logic          running_q;
   logic          tick;

   assign tick = (state_q == StRun) && (psc_q == PscMax);

   always_comb begin
      state_d = state_q;
      psc_d   = psc_q;
      digit_d = digit_q;
      carry_d = 1'b0;
      if (clear_press) begin
         state_d = StIdle;
         psc_d   = '0;
         digit_d = 4'd0;
      end else begin
         case (state_q)
            StIdle: begin
               psc_d   = '0;
               digit_d = 4'd0;
               if (start_press) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (tick) begin
                  psc_d = '0;
                  if (up_down) begin
                     if (digit_q >= 4'd9) begin
                        digit_d = 4'd0;
                        carry_d = 1'b1;
                     end else begin
                        digit_d = digit_q + 4'd1;
                     end
                  end else begin
                     if (digit_q == 4'd0) begin
                        digit_d = 4'd9;
                        carry_d = 1'b1;
                     end else begin
                        digit_d = digit_q - 4'd1;
                     end
                  end
               end else begin
                  psc_d = psc_q + PW'(1);
               end
               // A tick in the same cycle still takes effect before pausing.
               if (start_press) begin
                  state_d = StPause;
               end
            end
            StPause: begin
               if (start_press) begin
                  state_d = StRun;
               end
            end
            default: begin
               state_d = StIdle;
               psc_d   = '0;
               digit_d = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         psc_q     <= '0;
         digit_q   <= 4'd0;
         carry_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         psc_q     <= psc_d;
         digit_q   <= digit_d;
         carry_q   <= carry_d;
         running_q <= (state_d == StRun);
      end
   end

   assign digit1  = digit_q;
   assign carry   = carry_q;
   assign running = running_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Table-driven bench for bcd_digit_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Edge e = e-th rising edge after reset release; outputs are sampled 1 time unit after it.
module tb_bcd_digit_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start;
   logic       btn_clear;
   logic       up_down;
   logic [3:0] digit1;
   logic       carry;
   logic       running;

   bcd_digit_counter #(
      .TICK_DIV       (4),
      .DEBOUNCE_CYCLES(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_start(btn_start),
      .btn_clear(btn_clear),
      .up_down  (up_down),
      .digit1   (digit1),
      .carry    (carry),
      .running  (running)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   e;
      logic r;
      logic s;
      logic c;
      logic u;
   } stim_t;

   typedef struct {
      int         e;
      logic [3:0] d;
      logic       c;
      logic       r;
   } chk_t;

   stim_t stim_tab[$];
   chk_t  chk_tab[$];
   chk_t  sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic add_stim(input int e, input logic r, input logic s, input logic c,
                           input logic u);
      stim_t t;
      t.e = e; t.r = r; t.s = s; t.c = c; t.u = u;
      stim_tab.push_back(t);
   endtask

   task automatic add_chk(input int e, input logic [3:0] d, input logic c, input logic r);
      chk_t t;
      t.e = e; t.d = d; t.c = c; t.r = r;
      chk_tab.push_back(t);
   endtask

   task automatic check(input string name, input int e, input logic [3:0] act,
                        input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
      end
   endtask

   initial begin
      chk_t       x;
      chk_t       got;
      bit         found;
      int         k;

      // rst, btn_start, btn_clear, up_down applied before edge e
      add_stim(-2,  1'b1, 1'b0, 1'b0, 1'b1);
      add_stim(0,   1'b0, 1'b1, 1'b0, 1'b1);
      add_stim(5,   1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(51,  1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(52,  1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(55,  1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(72,  1'b0, 1'b1, 1'b0, 1'b0);
      add_stim(74,  1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(81,  1'b0, 1'b1, 1'b0, 1'b0);
      add_stim(86,  1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(108, 1'b0, 1'b1, 1'b0, 1'b0);
      add_stim(113, 1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(131, 1'b0, 1'b0, 1'b1, 1'b0);
      add_stim(136, 1'b0, 1'b0, 1'b0, 1'b0);
      add_stim(140, 1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(145, 1'b0, 1'b1, 1'b0, 1'b1);
      add_stim(150, 1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(160, 1'b0, 1'b1, 1'b1, 1'b1);
      add_stim(165, 1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(170, 1'b0, 1'b1, 1'b0, 1'b1);
      add_stim(175, 1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(207, 1'b1, 1'b0, 1'b0, 1'b1);
      add_stim(208, 1'b0, 1'b0, 1'b0, 1'b1);
      add_stim(228, 1'b0, 1'b1, 1'b0, 1'b1);
      add_stim(233, 1'b0, 1'b0, 1'b0, 1'b1);

      // edge, digit1, carry, running
      add_chk(-1,  4'd0, 1'b0, 1'b0);
      add_chk(6,   4'd0, 1'b0, 1'b1);
      add_chk(50,  4'd1, 1'b0, 1'b1);
      add_chk(53,  4'd1, 1'b0, 1'b1);
      add_chk(54,  4'd2, 1'b0, 1'b1);
      add_chk(58,  4'd1, 1'b0, 1'b1);
      add_chk(62,  4'd0, 1'b0, 1'b1);
      add_chk(65,  4'd0, 1'b0, 1'b1);
      add_chk(66,  4'd9, 1'b1, 1'b1);
      add_chk(67,  4'd9, 1'b0, 1'b1);
      add_chk(70,  4'd8, 1'b0, 1'b1);
      add_chk(76,  4'd7, 1'b0, 1'b1);
      add_chk(78,  4'd6, 1'b0, 1'b1);
      add_chk(86,  4'd4, 1'b0, 1'b1);
      add_chk(87,  4'd4, 1'b0, 1'b0);
      add_chk(113, 4'd4, 1'b0, 1'b0);
      add_chk(114, 4'd4, 1'b0, 1'b1);
      add_chk(116, 4'd4, 1'b0, 1'b1);
      add_chk(117, 4'd3, 1'b0, 1'b1);
      add_chk(133, 4'd9, 1'b1, 1'b1);
      add_chk(136, 4'd9, 1'b0, 1'b1);
      add_chk(137, 4'd0, 1'b0, 1'b0);
      add_chk(138, 4'd0, 1'b0, 1'b0);
      add_chk(150, 4'd0, 1'b0, 1'b0);
      add_chk(151, 4'd0, 1'b0, 1'b1);
      add_chk(155, 4'd1, 1'b0, 1'b1);
      add_chk(165, 4'd3, 1'b0, 1'b1);
      add_chk(166, 4'd0, 1'b0, 1'b0);
      add_chk(176, 4'd0, 1'b0, 1'b1);
      add_chk(204, 4'd7, 1'b0, 1'b1);
      add_chk(206, 4'd7, 1'b0, 1'b1);
      add_chk(207, 4'd0, 1'b0, 1'b0);
      add_chk(227, 4'd0, 1'b0, 1'b0);
      add_chk(233, 4'd0, 1'b0, 1'b0);
      add_chk(234, 4'd0, 1'b0, 1'b1);
      add_chk(237, 4'd0, 1'b0, 1'b1);
      add_chk(238, 4'd1, 1'b0, 1'b1);

      for (int e = -2; e <= 242; e++) begin
         foreach (stim_tab[i]) begin
            if (stim_tab[i].e == e) begin
               rst       = stim_tab[i].r;
               btn_start = stim_tab[i].s;
               btn_clear = stim_tab[i].c;
               up_down   = stim_tab[i].u;
            end
         end

         found = 1'b0;
         x.e   = e;
         if (e >= 0 && e <= 5) begin
            // Start press still working through the debouncer.
            x.d = 4'd0; x.c = 1'b0; x.r = 1'b0; found = 1'b1;
         end else if (e >= 7 && e <= 46) begin
            // Counting up from entry into RUN at edge 6: one step per 4 edges.
            k   = (e - 6) / 4;
            x.d = 4'(k % 10);
            x.c = ((e - 6) % 4 == 0) && (k % 10 == 0);
            x.r = 1'b1;
            found = 1'b1;
         end else if (e >= 88 && e <= 107) begin
            // Paused: digit frozen.
            x.d = 4'd4; x.c = 1'b0; x.r = 1'b0; found = 1'b1;
         end else begin
            foreach (chk_tab[i]) begin
               if (chk_tab[i].e == e) begin
                  x = chk_tab[i];
                  found = 1'b1;
               end
            end
         end
         if (found) sb.push_back(x);

         @(posedge clk);
         #1;

         if (sb.size() > 0 && sb[0].e == e) begin
            got = sb.pop_front();
            check("digit1",  e, digit1,        got.d);
            check("carry",   e, {3'b0, carry},   {3'b0, got.c});
            check("running", e, {3'b0, running}, {3'b0, got.r});
         end
      end

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
